bsk_led_scan: RTL and testbench

- Parametrised multi-bank driver for external latched LED buffers (e.g. 74x573-style) that share one LED data bus.
- Time-multiplexes CHANNELS command-indication words onto a registered data bus and pulses one latch-enable per bank.
- Supports programmable setup/pulse/hold timing, output polarity, and an on-change mode that only re-latches banks whose data changed.
- Sits between the command-indication logic (transmitter, receiver and further banks) and the LED buffer pins.

---
 rtl/bsk_led_scan.sv | 93 +++++++++
 tb/tb_bsk_led_scan.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bsk_led_scan.sv
// bsk_led_scan: drives CHANNELS latched LED buffers from one shared, registered data bus.
// Ports: clk, iRst_n (async active-low) | iLed bank words, iForce re-latch all banks
//        | oLe one-hot latch enables, oLed shared data bus, oBusy bank transaction active.
module bsk_led_scan #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int SETUP_CYC = 1,
  parameter int LE_CYC    = 1,
  parameter int HOLD_CYC  = 1,
  parameter int INVERT    = 1,
  parameter int ON_CHANGE = 0
) (
  input  logic                      clk,
  input  logic                      iRst_n,
  input  logic [CHANNELS*WIDTH-1:0] iLed,
  input  logic                      iForce,
  output logic [CHANNELS-1:0]       oLe,
  output logic [WIDTH-1:0]          oLed,
  output logic                      oBusy
);
  localparam int MAXC = SETUP_CYC > LE_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                           : (LE_CYC > HOLD_CYC ? LE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, LATCH, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, ptr_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] snap, snap_n, led_n, slice;
  logic [CHANNELS*WIDTH-1:0] shadow, shadow_n;
  logic [CHANNELS-1:0] force_f, force_n, le_n;
  logic sel, done;
  int lim;
  assign slice   = iLed[ptr*WIDTH +: WIDTH];
  assign ptr_inc = (ptr == PW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
  assign sel     = (ON_CHANGE == 0) || force_f[ptr] || (slice != shadow[ptr*WIDTH +: WIDTH]);
  assign lim     = state == SETUP ? SETUP_CYC : state == LATCH ? LE_CYC : HOLD_CYC;
  assign done    = cnt == CW'(lim - 1);
  assign oBusy   = state != IDLE;
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    snap_n   = snap;
    led_n    = oLed;
    shadow_n = shadow;
    force_n  = force_f;
    if (state == IDLE) begin
      if (sel) begin
        snap_n         = slice;
        led_n          = INVERT != 0 ? ~slice : slice;
        force_n[ptr]   = 1'b0;
        state_n        = SETUP;
      end else begin
        ptr_n = ptr_inc;
      end
    end else begin
      cnt_n = done ? '0 : cnt + 1'b1;
      if (done) begin
        state_n = state == SETUP ? LATCH : state == LATCH ? HOLD : IDLE;
        if (state == HOLD) begin
          shadow_n[ptr*WIDTH +: WIDTH] = snap;
          ptr_n                        = ptr_inc;
        end
      end
    end
    // a force request always wins over the IDLE clear of the same flag
    if (iForce) force_n = '1;
    // latch enable is registered, so it is decoded from the next state
    le_n = state_n == LATCH ? CHANNELS'(1) << ptr : '0;
  end
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      snap    <= '0;
      oLed    <= {WIDTH{1'(INVERT)}};
      shadow  <= '0;
      force_f <= '1;
      oLe     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      snap    <= snap_n;
      oLed    <= led_n;
      shadow  <= shadow_n;
      force_f <= force_n;
      oLe     <= le_n;
    end
  end
endmodule

// File: tb/tb_bsk_led_scan.sv
// tb_bsk_led_scan: directed checks of bsk_led_scan in periodic, slow-timing and on-change setups.
module tb_bsk_led_scan;
  logic clk = 0;
  logic rst0 = 0, rst1 = 0, rst2 = 0;
  logic f0 = 0, f1 = 0, f2 = 0;
  logic [31:0] led_a = {16'h00FF, 16'h1234};
  logic [63:0] led_c = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [1:0] le0, le1;
  logic [3:0] le2;
  logic [15:0] led0, led1, led2;
  logic busy0, busy1, busy2;
  int checks = 0, failures = 0;
  int cnt2[4];
  int ord[$];
  logic busy_seen, multi_le;
  logic [15:0] led_at2;
  always #5 clk = ~clk;
  bsk_led_scan d0 (.clk(clk), .iRst_n(rst0), .iLed(led_a), .iForce(f0), .oLe(le0), .oLed(led0), .oBusy(busy0));
  bsk_led_scan #(.SETUP_CYC(2), .LE_CYC(3), .HOLD_CYC(2), .INVERT(0)) d1 (
    .clk(clk), .iRst_n(rst1), .iLed(led_a), .iForce(f1), .oLe(le1), .oLed(led1), .oBusy(busy1));
  bsk_led_scan #(.CHANNELS(4), .ON_CHANGE(1)) d2 (
    .clk(clk), .iRst_n(rst2), .iLed(led_c), .iForce(f2), .oLe(le2), .oLed(led2), .oBusy(busy2));
  typedef struct {
    logic frc;
    logic [1:0] le;
    logic [15:0] led;
    logic busy;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic clr2();
    for (int k = 0; k < 4; k++) cnt2[k] = 0;
    ord.delete();
    busy_seen = 0;
    multi_le = 0;
    led_at2 = 'x;
  endtask
  task automatic run2(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy2) busy_seen = 1;
      if ($countones(le2) > 1) multi_le = 1;
      for (int k = 0; k < 4; k++)
        if (le2[k] && ord.size() < 64) begin
          cnt2[k]++;
          ord.push_back(k);
          if (k == 2) led_at2 = led2;
        end
    end
  endtask
  initial begin
    int w;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      w = i % 8;
      v[i].frc  = (i == 5);
      v[i].le   = w == 1 ? 2'b01 : w == 5 ? 2'b10 : 2'b00;
      v[i].led  = w < 4 ? 16'hEDCB : 16'hFF00;
      v[i].busy = (w != 3) && (w != 7);
    end
    repeat (3) @(negedge clk);
    chk("reset_le", le0, 0);
    chk("reset_led", led0, 16'hFFFF);
    chk("reset_busy", busy0, 0);
    chk("reset_led_noinv", led1, 16'h0000);
    rst0 = 1;
    rst1 = 1;
    for (int i = 0; i < 16; i++) begin
      f0 = v[i].frc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("periodic_%0d", i), {le0, led0, busy0}, {v[i].le, v[i].led, v[i].busy});
      w = i % 8;
      chk($sformatf("timing_%0d", i), {le1, led1},
          {(w >= 2 && w <= 4) ? (i < 8 ? 2'b01 : 2'b10) : 2'b00, i < 8 ? 16'h1234 : 16'h00FF});
    end
    f0 = 0;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = (le0 == 2'b10);
    end
    chk("wait_latch_bank1", ok, 1);
    #2 rst0 = 0;
    #1;
    chk("async_rst_le", le0, 0);
    chk("async_rst_led", led0, 16'hFFFF);
    @(negedge clk);
    rst0 = 1;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = (le0 != 0);
    end
    chk("restart_bank0", le0, 2'b01);
    rst2 = 1;
    f2 = 1;
    clr2();
    run2(1);
    f2 = 0;
    run2(39);
    chk("force_collide_b0", cnt2[0], 2);
    chk("force_collide_b1", cnt2[1], 1);
    chk("force_collide_b3", cnt2[3], 1);
    @(negedge clk);
    rst2 = 0;
    @(negedge clk);
    rst2 = 1;
    clr2();
    run2(40);
    for (int k = 0; k < 4; k++) chk($sformatf("post_reset_b%0d", k), cnt2[k], 1);
    clr2();
    run2(20);
    chk("static_quiet_busy", busy_seen, 0);
    chk("static_quiet_pulses", ord.size(), 0);
    led_c[47:32] = 16'hA5A5;
    clr2();
    run2(12);
    chk("change_b2_pulses", cnt2[2], 1);
    chk("change_total", ord.size(), 1);
    chk("change_led", led_at2, 16'h5A5A);
    clr2();
    f2 = 1;
    run2(1);
    f2 = 0;
    run2(29);
    for (int k = 0; k < 4; k++) chk($sformatf("force_b%0d", k), cnt2[k], 1);
    ok = ord.size() == 4;
    for (int k = 1; k < ord.size(); k++) if (ord[k] != (ord[k-1] + 1) % 4) ok = 0;
    chk("force_order", ok, 1);
    chk("onehot_le", multi_le, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
